// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared width, reset value and count type for the loadable up-counter
//   and anything that connects to it.
package counter_pkg;

  localparam int COUNTER_WIDTH = 8;
  localparam logic [COUNTER_WIDTH-1:0] COUNTER_RST_VAL = 8'h00;

  typedef logic [COUNTER_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/counter_if.sv
// counter_if
//   Signal bundle for driving and observing a counter instance.
//   The counter itself keeps flat ports because instances connect by position.
//   This bundle lets a controller (master) and the counter side (slave) share
//   one declaration of the control/data signals.
//   Signals:
//     count   - current counter value (slave -> master)
//     data_in - parallel load value    (master -> slave)
//     load    - synchronous load strobe
//     enable  - synchronous count-enable
interface counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             enable;

  modport master (
    input  count,
    output data_in,
    output load,
    output enable
  );

  modport slave (
    output count,
    input  data_in,
    input  load,
    input  enable
  );

endinterface : counter_if

// File: rtl/counter.sv
// counter
//   Loadable, enable-gated up-counter with a registered output.
//   Ports (positional order is part of the interface):
//     count   out WIDTH  current value, straight from the state register
//     data_in in  WIDTH  parallel load value
//     clk     in  1      rising-edge clock
//     rst_n   in  1      asynchronous active-low reset, forces RST_VAL
//     load    in  1      load strobe, highest priority
//     enable  in  1      count-enable, wraps modulo 2^WIDTH
module counter
  import counter_pkg::*;
#(
  parameter int               WIDTH   = COUNTER_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(COUNTER_RST_VAL)
) (
  output logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable
);

  logic [WIDTH-1:0] count_q;

  // Priority: load beats enable; otherwise hold. The carry out of the
  // increment is simply dropped, giving wrap-around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else if (load) begin
      count_q <= data_in;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule : counter

// File: tb/tb_counter.sv
module tb_counter;
  import counter_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  counter_if #(.WIDTH(COUNTER_WIDTH)) cif ();

  counter #(.WIDTH(COUNTER_WIDTH), .RST_VAL(COUNTER_RST_VAL)) dut (
    .count   (cif.count),
    .data_in (cif.data_in),
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cif.load),
    .enable  (cif.enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  name;
    logic   ld;
    logic   en;
    count_t din;
    count_t exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input count_t act, input count_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: count=%02h expected=%02h", name, act, exp);
    end else begin
      $display("ok   %s: count=%02h", name, act);
    end
  endtask

  // Drive controls on the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic ld, input logic en, input count_t din);
    @(negedge clk);
    cif.load    = ld;
    cif.enable  = en;
    cif.data_in = din;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic l, input logic e,
                              input count_t d, input count_t x);
    vec_t v;
    v.name = n; v.ld = l; v.en = e; v.din = d; v.exp = x;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: count=%02h expected=finish", cif.count);
    $fatal(1, "timeout");
  end

  initial begin
    int model;
    logic   r_ld;
    count_t r_d;
    total = 0;
    bad   = 0;
    rst_n       = 1'b1;
    cif.load    = 1'b0;
    cif.enable  = 1'b0;
    cif.data_in = '0;

    // Reset takes effect immediately, without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_async", cif.count, 8'h00);
    @(posedge clk); #1;
    check("reset_hold", cif.count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release_idle", cif.count, 8'h00);

    // Directed table: load, hold, increment through wrap, priority.
    vecs.push_back(mk("load_de",   1, 0, 8'hDE, 8'hDE));
    for (int i = 0; i < 5; i++) vecs.push_back(mk("hold_de", 0, 0, 8'h55, 8'hDE));
    vecs.push_back(mk("load_fd",   1, 0, 8'hFD, 8'hFD));
    vecs.push_back(mk("inc_fe",    0, 1, 8'h00, 8'hFE));
    vecs.push_back(mk("inc_ff",    0, 1, 8'h00, 8'hFF));
    vecs.push_back(mk("wrap_00",   0, 1, 8'h00, 8'h00));
    vecs.push_back(mk("inc_01",    0, 1, 8'h00, 8'h01));
    vecs.push_back(mk("load_33",   1, 0, 8'h33, 8'h33));
    vecs.push_back(mk("prio_10",   1, 1, 8'h10, 8'h10));
    vecs.push_back(mk("inc_11",    0, 1, 8'hAA, 8'h11));
    vecs.push_back(mk("load_ff",   1, 0, 8'hFF, 8'hFF));
    vecs.push_back(mk("wrap_ff",   0, 1, 8'h00, 8'h00));
    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].en, vecs[i].din);
      check(vecs[i].name, cif.count, vecs[i].exp);
    end

    // A load pulse that falls between edges must not be seen.
    @(negedge clk);
    cif.load = 1'b0; cif.enable = 1'b0; cif.data_in = 8'h99;
    #1 cif.load = 1'b1;
    #1 cif.load = 1'b0;
    @(posedge clk); #1;
    check("glitch_ignored", cif.count, 8'h00);

    // Random: model is "next = data if load, else +1 mod 256 if enable, else same".
    model = 0;
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 10; i++) begin
        r_ld = 1'($urandom_range(0, 1));
        r_d  = 8'($urandom);
        step(r_ld, logic'(phase), r_d);
        if (r_ld) model = int'(r_d);
        else if (phase == 1) model = (model + 1) % 256;
        check($sformatf("rand_en%0d_%0d", phase, i), cif.count, count_t'(model));
      end
    end

    // Async reset in the middle of counting, then resume from zero.
    step(1, 0, 8'h7A);
    check("pre_reset_7a", cif.count, 8'h7A);
    @(negedge clk);
    cif.load = 1'b0; cif.enable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_clear", cif.count, 8'h00);
    @(posedge clk); #1;
    check("mid_reset_hold", cif.count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_inc", cif.count, 8'h01);

    // Reset coinciding with a pending load discards the load.
    @(negedge clk);
    cif.load = 1'b1; cif.data_in = 8'hC3;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_over_load", cif.count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; cif.load = 1'b0; cif.enable = 1'b0;
    @(posedge clk); #1;
    check("reset_over_load_after", cif.count, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_counter
